// File: rtl/seq_pattern_detector_if.sv
// Bus bundle for seq_pattern_detector: serial stream, pattern programming,
// counter control and the registered match results.
interface seq_pattern_detector_if #(
    parameter int WIDTH = 3,
    parameter int NPAT  = 2,
    parameter int CNT_W = 8
);
    localparam int SEL_W = (NPAT > 1) ? $clog2(NPAT) : 1;

    logic             valid_in;
    logic             i;
    logic             overlap;
    logic [NPAT-1:0]  pat_enable;
    logic             pat_load;
    logic [SEL_W-1:0] pat_sel;
    logic [WIDTH-1:0] pat_value;
    logic             count_clr;
    logic [1:0]       o;
    logic [NPAT-1:0]  match_vec;
    logic [CNT_W-1:0] match_count;
    logic             count_sat;

    modport master (
        output valid_in, i, overlap, pat_enable, pat_load, pat_sel, pat_value, count_clr,
        input  o, match_vec, match_count, count_sat
    );

    modport slave (
        input  valid_in, i, overlap, pat_enable, pat_load, pat_sel, pat_value, count_clr,
        output o, match_vec, match_count, count_sat
    );
endinterface

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector with NPAT programmable WIDTH-bit patterns, optional
// non-overlapping mode and a saturating match counter.
module seq_pattern_detector #(
    parameter int WIDTH = 3,
    parameter int NPAT  = 2,
    parameter int CNT_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    seq_pattern_detector_if.slave bus
);
    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int SEL_W  = (NPAT > 1) ? $clog2(NPAT) : 1;
    localparam int HIT_W  = $clog2(NPAT + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);

    function automatic logic [WIDTH-1:0] pat_reset_value(input int k);
        if (k == 0) begin
            return {WIDTH{1'b1}};
        end else if (k == 1) begin
            return {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            return {WIDTH{1'b0}};
        end
    endfunction

    function automatic logic [1:0] encode_hits(input logic [HIT_W-1:0] n);
        if (n == {HIT_W{1'b0}}) begin
            return 2'b00;
        end else if (n == HIT_W'(1)) begin
            return 2'b10;
        end else begin
            return 2'b11;
        end
    endfunction

    logic [WIDTH-1:0]  hist_q, hist_d, hist_upd_s;
    logic [FILL_W-1:0] fill_q, fill_d, fill_upd_s;
    logic [WIDTH-1:0]  pat_q [NPAT];
    logic [WIDTH-1:0]  pat_d [NPAT];
    logic [NPAT-1:0]   hit_s, match_vec_q, match_vec_d;
    logic [HIT_W-1:0]  n_hit_s;
    logic [1:0]        o_q, o_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              sat_q, sat_d;
    logic              any_hit_s;

    // Compare the post-shift history against every enabled pattern.
    always_comb begin
        hist_upd_s = {hist_q[WIDTH-2:0], bus.i};
        if (fill_q == FILL_FULL) begin
            fill_upd_s = fill_q;
        end else begin
            fill_upd_s = fill_q + FILL_W'(1);
        end
        hit_s   = {NPAT{1'b0}};
        n_hit_s = {HIT_W{1'b0}};
        for (int k = 0; k < NPAT; k++) begin
            if (bus.valid_in && (fill_upd_s == FILL_FULL) && bus.pat_enable[k] &&
                (hist_upd_s == pat_q[k])) begin
                hit_s[k] = 1'b1;
                n_hit_s  = n_hit_s + HIT_W'(1);
            end else begin
                hit_s[k] = 1'b0;
            end
        end
        any_hit_s = |hit_s;
    end

    // Next-state for history, fill, patterns, results and counter.
    always_comb begin
        if (bus.valid_in) begin
            hist_d = hist_upd_s;
            if (any_hit_s && !bus.overlap) begin
                fill_d = {FILL_W{1'b0}};
            end else begin
                fill_d = fill_upd_s;
            end
        end else begin
            hist_d = hist_q;
            fill_d = fill_q;
        end

        // Out-of-range selects match no index and are dropped.
        for (int k = 0; k < NPAT; k++) begin
            if (bus.pat_load && (bus.pat_sel == SEL_W'(k))) begin
                pat_d[k] = bus.pat_value;
            end else begin
                pat_d[k] = pat_q[k];
            end
        end

        match_vec_d = hit_s;
        o_d         = encode_hits(n_hit_s);

        if (bus.count_clr) begin
            count_d = {CNT_W{1'b0}};
        end else if (any_hit_s && !(&count_q)) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
        sat_d = &count_d;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist_q      <= {WIDTH{1'b0}};
            fill_q      <= {FILL_W{1'b0}};
            match_vec_q <= {NPAT{1'b0}};
            o_q         <= 2'b00;
            count_q     <= {CNT_W{1'b0}};
            sat_q       <= 1'b0;
            for (int k = 0; k < NPAT; k++) begin
                pat_q[k] <= pat_reset_value(k);
            end
        end else begin
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_vec_q <= match_vec_d;
            o_q         <= o_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
            for (int k = 0; k < NPAT; k++) begin
                pat_q[k] <= pat_d[k];
            end
        end
    end

    assign bus.o           = o_q;
    assign bus.match_vec   = match_vec_q;
    assign bus.match_count = count_q;
    assign bus.count_sat   = sat_q;
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: vector table plus hand-written
// sequences for pattern loads, saturation and mid-interval reset.
module tb_seq_pattern_detector;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    seq_pattern_detector_if #(.WIDTH(3), .NPAT(2), .CNT_W(8)) ifc ();
    seq_pattern_detector_if #(.WIDTH(3), .NPAT(2), .CNT_W(2)) ifc2 ();

    seq_pattern_detector #(.WIDTH(3), .NPAT(2), .CNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (ifc.slave)
    );

    seq_pattern_detector #(.WIDTH(3), .NPAT(2), .CNT_W(2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (ifc2.slave)
    );

    assign ifc2.valid_in   = ifc.valid_in;
    assign ifc2.i          = ifc.i;
    assign ifc2.overlap    = ifc.overlap;
    assign ifc2.pat_enable = ifc.pat_enable;
    assign ifc2.pat_load   = ifc.pat_load;
    assign ifc2.pat_sel    = ifc.pat_sel;
    assign ifc2.pat_value  = ifc.pat_value;
    assign ifc2.count_clr  = ifc.count_clr;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit       rst;
        bit       v;
        bit       d;
        bit       ov;
        bit [1:0] en;
        bit [1:0] eo;
        bit [1:0] evec;
        int       ecnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit v, bit d, bit ov, bit [1:0] en,
                                bit [1:0] eo, bit [1:0] evec, int ecnt);
        vec_t t;
        t.rst = rst; t.v = v; t.d = d; t.ov = ov; t.en = en;
        t.eo = eo; t.evec = evec; t.ecnt = ecnt;
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " o"},     int'(ifc.o), 0);
        chk({nm, " vec"},   int'(ifc.match_vec), 0);
        chk({nm, " cnt"},   int'(ifc.match_count), 0);
        chk({nm, " sat"},   int'(ifc.count_sat), 0);
    endtask

    // Assert reset between edges, check the asynchronous clear, release.
    task automatic do_reset(input string nm);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk_zero(nm);
        #1;
        reset = 1'b0;
    endtask

    task automatic step(input bit v, input bit d);
        ifc.valid_in = v;
        ifc.i        = d;
        @(posedge clock);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        ifc.valid_in   = 1'b0;
        ifc.i          = 1'b0;
        ifc.overlap    = 1'b1;
        ifc.pat_enable = 2'b11;
        ifc.pat_load   = 1'b0;
        ifc.pat_sel    = 1'b0;
        ifc.pat_value  = 3'b000;
        ifc.count_clr  = 1'b0;
        #1;
        chk_zero("por");
        #7;
        reset = 1'b0;

        // Mixed stream, overlap on
        tbl.push_back(mk(1, 1, 1, 1, 2'b11, 2'b00, 2'b00, 0));
        tbl.push_back(mk(0, 1, 1, 1, 2'b11, 2'b00, 2'b00, 0));
        tbl.push_back(mk(0, 1, 1, 1, 2'b11, 2'b10, 2'b01, 1));
        tbl.push_back(mk(0, 1, 0, 1, 2'b11, 2'b00, 2'b00, 1));
        tbl.push_back(mk(0, 1, 0, 1, 2'b11, 2'b00, 2'b00, 1));
        tbl.push_back(mk(0, 1, 1, 1, 2'b11, 2'b10, 2'b10, 2));
        tbl.push_back(mk(0, 1, 1, 1, 2'b11, 2'b00, 2'b00, 2));
        tbl.push_back(mk(0, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2));
        tbl.push_back(mk(0, 1, 0, 1, 2'b11, 2'b00, 2'b00, 2));
        tbl.push_back(mk(0, 1, 1, 1, 2'b11, 2'b10, 2'b10, 3));
        // All ones, overlapping
        tbl.push_back(mk(1, 1, 1, 1, 2'b11, 2'b00, 2'b00, 0));
        tbl.push_back(mk(0, 1, 1, 1, 2'b11, 2'b00, 2'b00, 0));
        tbl.push_back(mk(0, 1, 1, 1, 2'b11, 2'b10, 2'b01, 1));
        tbl.push_back(mk(0, 1, 1, 1, 2'b11, 2'b10, 2'b01, 2));
        tbl.push_back(mk(0, 1, 1, 1, 2'b11, 2'b10, 2'b01, 3));
        tbl.push_back(mk(0, 1, 1, 1, 2'b11, 2'b10, 2'b01, 4));
        // All ones, non-overlapping
        tbl.push_back(mk(1, 1, 1, 0, 2'b11, 2'b00, 2'b00, 0));
        tbl.push_back(mk(0, 1, 1, 0, 2'b11, 2'b00, 2'b00, 0));
        tbl.push_back(mk(0, 1, 1, 0, 2'b11, 2'b10, 2'b01, 1));
        tbl.push_back(mk(0, 1, 1, 0, 2'b11, 2'b00, 2'b00, 1));
        tbl.push_back(mk(0, 1, 1, 0, 2'b11, 2'b00, 2'b00, 1));
        tbl.push_back(mk(0, 1, 1, 0, 2'b11, 2'b10, 2'b01, 2));
        // Gaps in valid_in hold history and fill, and clear the outputs
        tbl.push_back(mk(1, 1, 1, 1, 2'b11, 2'b00, 2'b00, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 0));
        tbl.push_back(mk(0, 1, 1, 1, 2'b11, 2'b00, 2'b00, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 0));
        tbl.push_back(mk(0, 1, 1, 1, 2'b11, 2'b10, 2'b01, 1));
        tbl.push_back(mk(0, 0, 1, 1, 2'b11, 2'b00, 2'b00, 1));
        // pat_enable masks, and a change takes effect on its own edge
        tbl.push_back(mk(1, 1, 1, 1, 2'b10, 2'b00, 2'b00, 0));
        tbl.push_back(mk(0, 1, 1, 1, 2'b10, 2'b00, 2'b00, 0));
        tbl.push_back(mk(0, 1, 1, 1, 2'b10, 2'b00, 2'b00, 0));
        tbl.push_back(mk(0, 1, 1, 1, 2'b01, 2'b10, 2'b01, 1));

        foreach (tbl[n]) begin
            if (tbl[n].rst) do_reset($sformatf("rst@%0d", n));
            ifc.overlap    = tbl[n].ov;
            ifc.pat_enable = tbl[n].en;
            step(tbl[n].v, tbl[n].d);
            chk($sformatf("vec%0d o", n),   int'(ifc.o),           int'(tbl[n].eo));
            chk($sformatf("vec%0d mv", n),  int'(ifc.match_vec),   int'(tbl[n].evec));
            chk($sformatf("vec%0d cnt", n), int'(ifc.match_count), tbl[n].ecnt);
        end
        ifc.overlap    = 1'b1;
        ifc.pat_enable = 2'b11;

        // Reprogram pattern 1 to 111: both patterns hit together
        do_reset("rst load");
        ifc.pat_load  = 1'b1;
        ifc.pat_sel   = 1'b1;
        ifc.pat_value = 3'b111;
        step(1'b0, 1'b0);
        ifc.pat_load  = 1'b0;
        chk("load gap o", int'(ifc.o), 0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("dual o",   int'(ifc.o), 3);
        chk("dual mv",  int'(ifc.match_vec), 3);
        chk("dual cnt", int'(ifc.match_count), 1);

        // Load on the matching edge still compares the old pattern
        do_reset("rst same-edge");
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        ifc.pat_load  = 1'b1;
        ifc.pat_sel   = 1'b0;
        ifc.pat_value = 3'b000;
        step(1'b1, 1'b1);
        ifc.pat_load  = 1'b0;
        chk("old pat o",  int'(ifc.o), 2);
        chk("old pat mv", int'(ifc.match_vec), 1);
        step(1'b1, 1'b1);
        chk("new pat o",   int'(ifc.o), 0);
        chk("new pat cnt", int'(ifc.match_count), 1);

        // Saturation on the 2-bit counter, then clear beats increment
        do_reset("rst sat");
        for (int k = 0; k < 5; k++) step(1'b1, 1'b1);
        chk("sat3 cnt2",  int'(ifc2.match_count), 3);
        chk("sat3 sat2",  int'(ifc2.count_sat), 1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("sat5 cnt2",  int'(ifc2.match_count), 3);
        chk("sat5 sat2",  int'(ifc2.count_sat), 1);
        chk("sat5 cnt8",  int'(ifc.match_count), 5);
        chk("sat5 sat8",  int'(ifc.count_sat), 0);
        ifc.count_clr = 1'b1;
        step(1'b1, 1'b1);
        ifc.count_clr = 1'b0;
        chk("clr o",     int'(ifc.o), 2);
        chk("clr cnt8",  int'(ifc.match_count), 0);
        chk("clr cnt2",  int'(ifc2.match_count), 0);
        chk("clr sat2",  int'(ifc2.count_sat), 0);

        // Reset between edges clears outputs, history and fill
        do_reset("rst mid");
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1);
        chk("pre mid o",   int'(ifc.o), 2);
        chk("pre mid cnt", int'(ifc.match_count), 2);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("mid rst");
        #1;
        reset = 1'b0;
        step(1'b1, 1'b1);
        chk("post rst b1 o", int'(ifc.o), 0);
        step(1'b1, 1'b1);
        chk("post rst b2 o", int'(ifc.o), 0);
        step(1'b1, 1'b1);
        chk("post rst b3 o", int'(ifc.o), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
